sponge_io_sequencer: RTL

- Parametrised absorb/squeeze sequencer for the slice-parallel Keccak core, generalising the fixed 128/256 rate mux to four runtime rates.
- Streams whole WIN-bit message words into state-RAM chunk writes, generates cSHAKE/SHAKE padding, requests permutations at rate boundaries, then reads the state back and emits WOUT-bit words on a valid/ready interface.
- Sits between the host stream and state_ram/permutation control.

---
 rtl/sponge_io_sequencer.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sponge_io_sequencer.sv
// sponge_io_sequencer: absorb/pad/squeeze sequencer for a slice-parallel
// Keccak core with four runtime rates and a valid/ready host interface.
module sponge_io_sequencer #(
  parameter  int         WIN    = 32,
  parameter  int         WOUT   = 32,
  parameter  int         PS     = 16,
  parameter  logic [7:0] DOMAIN = 8'h04,
  localparam int         NC     = 64 / PS,
  localparam int         CW     = (NC > 1) ? $clog2(NC) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [15:0]     out_words,
  input  logic            in_valid,
  input  logic [WIN-1:0]  in_data,
  input  logic            in_last,
  output logic            in_ready,
  output logic            wr_en,
  output logic [4:0]      wr_lane,
  output logic [CW-1:0]   wr_chunk,
  output logic [PS-1:0]   wr_data,
  output logic            perm_req,
  input  logic            perm_done,
  output logic            rd_en,
  output logic [4:0]      rd_lane,
  output logic [CW-1:0]   rd_chunk,
  input  logic [PS-1:0]   rd_data,
  output logic            out_valid,
  output logic [WOUT-1:0] out_data,
  input  logic            out_ready,
  output logic            busy,
  output logic            done
);

  localparam int            B       = WIN / PS;
  localparam int            R       = WOUT / PS;
  localparam logic [CW-1:0] C_LAST  = CW'(NC - 1);
  localparam logic [3:0]    B_CNT   = 4'(B);
  localparam logic [3:0]    RD_LAST = 4'(R - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABSORB,
    S_PERM_A,
    S_PAD,
    S_PERM_P,
    S_SQ_READ,
    S_SQ_OUT,
    S_PERM_S
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [4:0]      r_lane;
  logic [CW-1:0]   r_chunk;
  logic [4:0]      r_L;
  logic [15:0]     r_words;
  logic [3:0]      r_beats;
  logic [WIN-1:0]  r_buf;
  logic            r_last_seen;
  logic            r_pad_first;
  logic            r_perm_req;
  logic            r_done;
  logic [3:0]      r_rd_cnt;
  logic            r_cap_en;
  logic [3:0]      r_cap_idx;
  logic [WOUT-1:0] r_out_data;
  logic            r_out_valid;

  logic [4:0]      w_L_sel;
  logic [4:0]      w_lane_nx;
  logic [CW-1:0]   w_chunk_nx;
  logic            w_at_end;
  logic            w_ptr_zero;
  logic            w_beat;
  logic            w_pad;
  logic            w_accept;
  logic            w_hs;
  logic            w_adv;
  logic            w_perm_ok;
  logic            w_perm_req_n;
  logic            w_done_n;
  logic [PS-1:0]   w_wr_data;

  assign w_at_end   = (r_lane == r_L - 5'd1) && (r_chunk == C_LAST);
  assign w_ptr_zero = (r_lane == 5'd0) && (r_chunk == '0);
  assign w_beat     = (r_state == S_ABSORB) && (r_beats != 4'd0);
  assign w_pad      = (r_state == S_PAD);
  assign w_hs       = (r_state == S_SQ_OUT) && r_out_valid && out_ready;
  assign w_adv      = w_beat || w_pad || (r_state == S_SQ_READ);
  assign w_perm_ok  = perm_done && !r_perm_req;

  // Ready only between words, never once the rate block is about to close.
  assign in_ready = (r_state == S_ABSORB) && !r_last_seen &&
                    ((r_beats == 4'd0) ||
                     ((r_beats == 4'd1) && !w_at_end));
  assign w_accept = in_valid && in_ready;

  assign wr_en     = w_beat || w_pad;
  assign wr_lane   = wr_en ? r_lane : 5'd0;
  assign wr_chunk  = wr_en ? r_chunk : '0;
  assign wr_data   = w_wr_data;
  assign rd_en     = (r_state == S_SQ_READ);
  assign rd_lane   = rd_en ? r_lane : 5'd0;
  assign rd_chunk  = rd_en ? r_chunk : '0;
  assign perm_req  = r_perm_req;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

  // Rate in lanes selected by mode.
  always_comb begin
    w_L_sel = 5'd21;
    unique case (mode)
      2'd0: w_L_sel = 5'd21;
      2'd1: w_L_sel = 5'd17;
      2'd2: w_L_sel = 5'd13;
      2'd3: w_L_sel = 5'd9;
      default: w_L_sel = 5'd21;
    endcase
  end

  // Next chunk pointer, wrapping at the end of the rate.
  always_comb begin
    w_chunk_nx = r_chunk + CW'(1);
    w_lane_nx  = r_lane;
    if (r_chunk == C_LAST) begin
      w_chunk_nx = '0;
      w_lane_nx  = w_at_end ? 5'd0 : r_lane + 5'd1;
    end
  end

  // Write data: message beats, or padding with domain and final bit.
  always_comb begin
    w_wr_data = '0;
    if (w_beat) begin
      w_wr_data = r_buf[PS-1:0];
    end else if (w_pad) begin
      if (r_pad_first) w_wr_data = w_wr_data | PS'(DOMAIN);
      if (w_at_end)    w_wr_data[PS-1] = 1'b1;
    end
  end

  // Next-state and one-cycle pulse decode.
  always_comb begin
    w_state_n    = r_state;
    w_perm_req_n = 1'b0;
    w_done_n     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_n = S_ABSORB;
      end
      S_ABSORB: begin
        if (w_beat && w_at_end) begin
          w_state_n    = S_PERM_A;
          w_perm_req_n = 1'b1;
        end else if (w_beat && (r_beats == 4'd1) && r_last_seen) begin
          w_state_n = S_PAD;
        end
      end
      S_PERM_A: begin
        if (w_perm_ok) w_state_n = r_last_seen ? S_PAD : S_ABSORB;
      end
      S_PAD: begin
        if (w_at_end) begin
          w_state_n    = S_PERM_P;
          w_perm_req_n = 1'b1;
        end
      end
      S_PERM_P: begin
        if (w_perm_ok) begin
          if (r_words == 16'd0) begin
            w_state_n = S_IDLE;
            w_done_n  = 1'b1;
          end else begin
            w_state_n = S_SQ_READ;
          end
        end
      end
      S_SQ_READ: begin
        if (r_rd_cnt == RD_LAST) w_state_n = S_SQ_OUT;
      end
      S_SQ_OUT: begin
        if (w_hs) begin
          if (r_words == 16'd1) begin
            w_state_n = S_IDLE;
            w_done_n  = 1'b1;
          end else if (w_ptr_zero) begin
            w_state_n    = S_PERM_S;
            w_perm_req_n = 1'b1;
          end else begin
            w_state_n = S_SQ_READ;
          end
        end
      end
      S_PERM_S: begin
        if (w_perm_ok) w_state_n = S_SQ_READ;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State register and registered control pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_perm_req  <= 1'b0;
      r_done      <= 1'b0;
      r_pad_first <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_perm_req  <= w_perm_req_n;
      r_done      <= w_done_n;
      r_pad_first <= (w_state_n == S_PAD) && (r_state != S_PAD);
    end
  end

  // Chunk pointer, rate and word-count bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane  <= 5'd0;
      r_chunk <= '0;
      r_L     <= 5'd0;
      r_words <= 16'd0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_lane  <= 5'd0;
        r_chunk <= '0;
        r_L     <= w_L_sel;
        r_words <= out_words;
      end else if (w_adv) begin
        r_lane  <= w_lane_nx;
        r_chunk <= w_chunk_nx;
      end
      if (w_hs) r_words <= r_words - 16'd1;
    end
  end

  // Absorb word buffer: one chunk shifted out per beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf       <= '0;
      r_beats     <= 4'd0;
      r_last_seen <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_beats     <= 4'd0;
        r_last_seen <= 1'b0;
      end
      if (w_beat) begin
        r_buf   <= r_buf >> PS;
        r_beats <= r_beats - 4'd1;
      end
      if (w_accept) begin
        r_buf   <= in_data;
        r_beats <= B_CNT;
        if (in_last) r_last_seen <= 1'b1;
      end
    end
  end

  // Squeeze: read counter, one-cycle-late capture, output hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt    <= 4'd0;
      r_cap_en    <= 1'b0;
      r_cap_idx   <= 4'd0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_cap_en  <= rd_en;
      r_cap_idx <= r_rd_cnt;
      if (rd_en) begin
        r_rd_cnt <= (r_rd_cnt == RD_LAST) ? 4'd0 : r_rd_cnt + 4'd1;
      end
      if (r_cap_en) begin
        for (int k = 0; k < R; k++) begin
          if (r_cap_idx == 4'(k)) r_out_data[k*PS +: PS] <= rd_data;
        end
        if (r_cap_idx == RD_LAST) r_out_valid <= 1'b1;
      end
      if (w_hs) r_out_valid <= 1'b0;
    end
  end

endmodule
